// File: rtl/fake_jpeg_cone_pipe.sv
// fake_jpeg_cone_pipe
//   Three-stage bitwise logic cone with a rolling frame signature.
//   Per bit: p = ~(a|b), q = ~(c&d), r = MAJ(p,q,e), y = ~(r&f).
//   Stage 1 registers p/q, stage 2 registers r, stage 3 registers y.
//   A single global stall freezes every stage while the output is blocked.
//   Each output handshake folds y into a rotate-xor accumulator. Every FRAME
//   handshakes the folded value is published on sig_value, with a
//   one-cycle sig_valid pulse.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   clear                  synchronous flush of pipeline, accumulator, counter
//   in_a..in_f [W]         operands, qualified by in_valid / in_ready
//   out_y [W]              cone result, qualified by out_valid / out_ready
//   sig_valid, sig_value   frame signature pulse and held value
//   frame_cnt              output handshakes counted in the current frame
module fake_jpeg_cone_pipe #(
    parameter int W     = 8,
    parameter int FRAME = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic [W-1:0]             in_c,
    input  logic [W-1:0]             in_d,
    input  logic [W-1:0]             in_e,
    input  logic [W-1:0]             in_f,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [W-1:0]             out_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sig_valid,
    output logic [W-1:0]             sig_value,
    output logic [$clog2(FRAME)-1:0] frame_cnt
);
    localparam int            CW       = $clog2(FRAME);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

    logic          en;
    logic          hs_out;
    logic [W-1:0]  acc_next;

    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [W-1:0]  p_q, p_d, q_q, q_d, e1_q, e1_d, f1_q, f1_d;
    logic [W-1:0]  r_q, r_d, f2_q, f2_d, y_q, y_d;
    logic [W-1:0]  acc_q, acc_d, sig_q, sig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sigv_q, sigv_d;

    // Only a blocked, valid output stalls the pipe, so bubbles are squeezed
    // out whenever the consumer is ready.
    assign en       = !(v3_q && !out_ready);
    assign in_ready = en && !clear;
    assign hs_out   = v3_q && out_ready;
    assign acc_next = {acc_q[W-2:0], acc_q[W-1]} ^ y_q;

    always_comb begin : pipe_comb
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        p_d  = p_q;
        q_d  = q_q;
        e1_d = e1_q;
        f1_d = f1_q;
        r_d  = r_q;
        f2_d = f2_q;
        y_d  = y_q;
        if (clear) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            // Data registers only load behind a valid so bubbles never
            // disturb the value presented on out_y.
            if (in_valid) begin
                p_d  = ~(in_a | in_b);
                q_d  = ~(in_c & in_d);
                e1_d = in_e;
                f1_d = in_f;
            end
            if (v1_q) begin
                r_d  = (p_q & q_q) | (p_q & e1_q) | (q_q & e1_q);
                f2_d = f1_q;
            end
            if (v2_q) begin
                y_d = ~(r_q & f2_q);
            end
        end
    end

    always_comb begin : frame_comb
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        sigv_d = 1'b0;
        // A handshake that coincides with clear is consumed but not counted.
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (hs_out) begin
            if (cnt_q == CNT_LAST) begin
                sig_d  = acc_next;
                sigv_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p_q    <= '0;
            q_q    <= '0;
            e1_q   <= '0;
            f1_q   <= '0;
            r_q    <= '0;
            f2_q   <= '0;
            y_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            sig_q  <= '0;
            sigv_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            p_q    <= p_d;
            q_q    <= q_d;
            e1_q   <= e1_d;
            f1_q   <= f1_d;
            r_q    <= r_d;
            f2_q   <= f2_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
            sigv_q <= sigv_d;
        end
    end

    assign out_y     = y_q;
    assign out_valid = v3_q;
    assign sig_valid = sigv_q;
    assign sig_value = sig_q;
    assign frame_cnt = cnt_q;

endmodule
